fsm_display: RTL and testbench
==============================

# fsm_display

Output-side companion to the button-driven FSM front end. It captures the FSM state code, the output code and a step count on each one-cycle step strobe, then drives a 4-digit common-anode seven-segment display by time-multiplexing. A blanking gap between digits suppresses ghosting. Displayed data changes only at digit-slot boundaries, never mid-slot.

## Interface
- REFRESH_DIV, 100000: cycles each digit is lit (SHOW slot); legal minimum 2
- BLANK_CYCLES, 1000: cycles all anodes are off between digits (BLANK slot); legal minimum 1
- clk_100MHz  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high
- load  input  1  one-cycle step strobe; captures cs_in/out_in and increments the step count
- cs_in  input  3  FSM current-state code, sampled only when load=1
- out_in  input  2  FSM output code, sampled only when load=1
- an  output  4  digit anodes, active-low, at most one low at a time
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

## Operation
- Shadow registers: cs_q[2:0], out_q[1:0], step_tens[3:0], step_ones[3:0] (BCD).
- load=1 → cs_q←cs_in, out_q←out_in; the BCD step count increments.
  - ones 9 → 0 carries into tens.
  - 99 → 00 wraps.
- Digit map:
  - an[0] = out_q (0–3)
  - an[1] = cs_q (0–7)
  - an[2] = step_ones
  - an[3] = step_tens
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- dp=0 only while digit 2 is in SHOW; otherwise dp=1.
- Scan FSM:
  - State: {BLANK, SHOW}, digit index idx[1:0], slot timer.
  - BLANK: an=1111, seg=1111111, dp=1. At timer==BLANK_CYCLES-1 → SHOW, idx←idx+1 (3 wraps to 0), timer←0.
  - SHOW: an has bit idx low. seg/dp hold the code latched on SHOW entry. At timer==REFRESH_DIV-1 → BLANK, timer←0.
- Latch rule: segment data for a slot is computed from the shadow registers as they stand on the SHOW-entry clock edge.
  - The registered an, seg and dp all update on that same edge.
  - A load during SHOW does not alter the lit digit; it appears at that digit's next SHOW slot.
- Reset values:
  - State BLANK, idx=3, timer=0.
  - an=1111, seg=1111111, dp=1.
  - cs_q=0, out_q=0, step count=00.
- Reset has priority over load in the same cycle.
- Reset mid-SHOW blanks outputs on the next edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- Counting from the first edge with reset=0:
  - BLANK occupies edges 1..BLANK_CYCLES.
  - an[0] goes low on edge BLANK_CYCLES.
- Each digit lights for exactly REFRESH_DIV cycles, followed by exactly BLANK_CYCLES dark cycles.
- Full frame = 4·(REFRESH_DIV+BLANK_CYCLES) cycles; defaults give 404000 cycles ≈ 247.5 Hz frame rate.
- Shadow registers update on the edge where load=1, with one-cycle latency to the shadow registers.
- Latency from load to the visible digit change is at most one frame plus one cycle.
- Back-to-back load pulses on consecutive cycles each count: 2 pulses add 2.

## Test plan
Bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset release, no load → 2 cycles of an=1111/seg=1111111. Then an=1110 and seg=1000000 for 8 cycles. Then 2 blank cycles, then an=1101 with seg=1000000. Frame repeats every 40 cycles.
- load with cs_in=3'b011, out_in=2'b10 → next an[0] slot shows seg=0100100 ("2"), an[1] slot shows 0110000 ("3"), an[2] slot shows "1" with dp=0, an[3] slot shows "0".
- load pulsed mid-slot while an[1] is lit with a new cs_in=3'b100 → seg is unchanged for the rest of that slot. The next an[1] slot shows 0011001.
- 99 load pulses, then 1 more → count reads 99 (an[3]="9", an[2]="9"), then 00.
- Reset asserted during SHOW together with load=1 → the next cycle has an=1111. Count=00 and cs_q=out_q=0. The restart sequence matches the first scenario.
- Over 3 full frames with random loads → an is never two-hot, and every digit appears once per 40-cycle frame.

Source files
------------

// File: rtl/fsm_display.sv
// Captures FSM state/output codes and a BCD step count, scans them onto a 4-digit seven-segment display.
// Latency: shadow registers update 1 cycle after load; a change is visible at the next SHOW slot of its digit.
// Backpressure: none; every load strobe is accepted, and display data changes only on SHOW-entry edges.
module fsm_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] cs_in,
    input  logic [1:0] out_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // One timer serves both slot kinds, so size it for the longer one.
    localparam int TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] SHOW_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [2:0]    cs_q;
    logic [1:0]    out_q;
    logic [3:0]    step_tens;
    logic [3:0]    step_ones;

    logic [0:0]    state;
    logic [1:0]    idx;
    logic [TW-1:0] timer;

    logic [1:0]    idx_nxt;
    logic [3:0]    nxt_val;

    // Active-low gfedcba pattern for one decimal digit; anything else stays dark.
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = 7'b1111111;
        endcase
        return c;
    endfunction

    // Shadow registers: capture the FSM codes and bump the two-digit BCD step count on each load.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            cs_q      <= 3'd0;
            out_q     <= 2'd0;
            step_tens <= 4'd0;
            step_ones <= 4'd0;
        end else if (load) begin
            cs_q  <= cs_in;
            out_q <= out_in;
            if (step_ones == 4'd9) begin
                step_ones <= 4'd0;
                step_tens <= (step_tens == 4'd9) ? 4'd0 : step_tens + 4'd1;
            end else begin
                step_ones <= step_ones + 4'd1;
            end
        end
    end

    // Value of the digit that the upcoming SHOW slot will light.
    always_comb begin
        idx_nxt = idx + 2'd1;
        nxt_val = 4'd0;
        case (idx_nxt)
            2'd0: nxt_val = {2'b00, out_q};
            2'd1: nxt_val = {1'b0, cs_q};
            2'd2: nxt_val = step_ones;
            2'd3: nxt_val = step_tens;
            default: nxt_val = 4'd0;
        endcase
    end

    // Scan FSM: alternate dark gaps and lit slots; outputs are latched only on slot boundaries.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= ST_BLANK;
            idx   <= 2'd3;
            timer <= '0;
            an    <= 4'b1111;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (timer == BLANK_LAST) begin
                        state <= ST_SHOW;
                        idx   <= idx_nxt;
                        timer <= '0;
                        an    <= ~(4'b0001 << idx_nxt);
                        seg   <= seg_code(nxt_val);
                        dp    <= (idx_nxt != 2'd2);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    if (timer == SHOW_LAST) begin
                        state <= ST_BLANK;
                        timer <= '0;
                        an    <= 4'b1111;
                        seg   <= 7'b1111111;
                        dp    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_display.sv
// Directed bench for fsm_display with an 8-cycle lit slot and a 2-cycle dark gap (40-cycle frame).
// Expected outputs come from the frame timing: after edge c (c>=2), k=c-2, digit=(k%40)/10, lit while k%10<8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_fsm_display;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       load       = 1'b0;
    logic [2:0] cs_in      = 3'd0;
    logic [1:0] out_in     = 2'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;
    int ev [4];

    logic [6:0] lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    fsm_display #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .load       (load),
        .cs_in      (cs_in),
        .out_in     (out_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic lit_at(input int c);
        if (c < 2) return 1'b0;
        return ((c - 2) % 10) < 8;
    endfunction

    function automatic int dig_at(input int c);
        return ((c - 2) % 40) / 10;
    endfunction

    function automatic int slot_at(input int c);
        return (c - 2) % 10;
    endfunction

    function automatic logic [3:0] exp_an(input int c);
        if (!lit_at(c)) return 4'b1111;
        return ~(4'b0001 << dig_at(c));
    endfunction

    function automatic logic [6:0] exp_seg(input int c);
        if (!lit_at(c)) return 7'b1111111;
        return lut[ev[dig_at(c)]];
    endfunction

    function automatic logic exp_dp(input int c);
        if (!lit_at(c)) return 1'b1;
        return dig_at(c) != 2;
    endfunction

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
        cyc++;
    endtask

    task automatic wait_phase(input int d, input int s, input string name);
        int n = 0;
        while (!(cyc >= 2 && dig_at(cyc) == d && slot_at(cyc) == s) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            tests++;
            errors++;
            $display("FAIL %s: phase digit %0d slot %0d not reached in 100 cycles", name, d, s);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: an=%b seg=%b dp=%b, want 1111 1111111 1", an, seg, dp);
        end
        reset = 1'b0;
        cyc   = 0;
        ev    = '{0, 0, 0, 0};
        for (int i = 0; i < 45; i++) begin
            tests++;
            if (an !== exp_an(cyc) || seg !== exp_seg(cyc) || dp !== exp_dp(cyc)) begin
                errors++;
                $display("FAIL reset_scan cyc=%0d: an=%b seg=%b dp=%b, want %b %b %b",
                         cyc, an, seg, dp, exp_an(cyc), exp_seg(cyc), exp_dp(cyc));
            end
            tick();
        end
    endtask

    task automatic test_load_display();
        cs_in  = 3'b011;
        out_in = 2'b10;
        load   = 1'b1;
        tick();
        load = 1'b0;
        ev   = '{2, 3, 1, 0};
        tick();
        wait_phase(0, 0, "load_display");
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (an !== exp_an(cyc) || seg !== exp_seg(cyc) || dp !== exp_dp(cyc)) begin
                errors++;
                $display("FAIL load_display cyc=%0d: an=%b seg=%b dp=%b, want %b %b %b",
                         cyc, an, seg, dp, exp_an(cyc), exp_seg(cyc), exp_dp(cyc));
            end
            tick();
        end
    endtask

    task automatic test_mid_slot_load();
        wait_phase(1, 3, "mid_slot");
        tests++;
        if (seg !== 7'b0110000) begin
            errors++;
            $display("FAIL mid_slot_before: seg=%b, want 0110000", seg);
        end
        cs_in = 3'b100;
        load  = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (an !== 4'b1101 || seg !== 7'b0110000) begin
                errors++;
                $display("FAIL mid_slot_hold cyc=%0d: an=%b seg=%b, want 1101 0110000", cyc, an, seg);
            end
            tick();
        end
        wait_phase(1, 0, "mid_slot_next");
        tests++;
        if (an !== 4'b1101 || seg !== 7'b0011001) begin
            errors++;
            $display("FAIL mid_slot_next: an=%b seg=%b, want 1101 0011001", an, seg);
        end
        ev = '{2, 4, 2, 0};
    endtask

    task automatic test_back_to_back();
        load = 1'b1;
        tick();
        tick();
        load  = 1'b0;
        ev[2] = 4;
        tick();
        wait_phase(0, 0, "back_to_back");
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (an !== exp_an(cyc) || seg !== exp_seg(cyc) || dp !== exp_dp(cyc)) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d: an=%b seg=%b dp=%b, want %b %b %b",
                         cyc, an, seg, dp, exp_an(cyc), exp_seg(cyc), exp_dp(cyc));
            end
            tick();
        end
    endtask

    task automatic test_bcd_wrap();
        load = 1'b1;
        repeat (95) tick();
        load  = 1'b0;
        ev[2] = 9;
        ev[3] = 9;
        tick();
        wait_phase(0, 0, "bcd_99");
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (an !== exp_an(cyc) || seg !== exp_seg(cyc) || dp !== exp_dp(cyc)) begin
                errors++;
                $display("FAIL bcd_99 cyc=%0d: an=%b seg=%b dp=%b, want %b %b %b",
                         cyc, an, seg, dp, exp_an(cyc), exp_seg(cyc), exp_dp(cyc));
            end
            tick();
        end
        load = 1'b1;
        tick();
        load  = 1'b0;
        ev[2] = 0;
        ev[3] = 0;
        tick();
        wait_phase(0, 0, "bcd_00");
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (an !== exp_an(cyc) || seg !== exp_seg(cyc) || dp !== exp_dp(cyc)) begin
                errors++;
                $display("FAIL bcd_00 cyc=%0d: an=%b seg=%b dp=%b, want %b %b %b",
                         cyc, an, seg, dp, exp_an(cyc), exp_seg(cyc), exp_dp(cyc));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_show();
        wait_phase(1, 4, "reset_mid_show");
        reset  = 1'b1;
        load   = 1'b1;
        cs_in  = 3'b111;
        out_in = 2'b11;
        tick();
        tests++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_show_blank: an=%b seg=%b dp=%b, want 1111 1111111 1", an, seg, dp);
        end
        reset = 1'b0;
        load  = 1'b0;
        cyc   = 0;
        ev    = '{0, 0, 0, 0};
        for (int i = 0; i < 45; i++) begin
            tests++;
            if (an !== exp_an(cyc) || seg !== exp_seg(cyc) || dp !== exp_dp(cyc)) begin
                errors++;
                $display("FAIL reset_restart cyc=%0d: an=%b seg=%b dp=%b, want %b %b %b",
                         cyc, an, seg, dp, exp_an(cyc), exp_seg(cyc), exp_dp(cyc));
            end
            tick();
        end
    endtask

    task automatic test_random_onehot();
        int cnt [4] = '{0, 0, 0, 0};
        wait_phase(0, 0, "onehot");
        for (int i = 0; i < 120; i++) begin
            tests++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL onehot cyc=%0d: an=%b has more than one digit lit", cyc, an);
            end
            for (int d = 0; d < 4; d++) begin
                if (an == ~(4'b0001 << d)) cnt[d]++;
            end
            load   = 1'($urandom_range(0, 1));
            cs_in  = 3'($urandom_range(0, 7));
            out_in = 2'($urandom_range(0, 3));
            tick();
        end
        load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            tests++;
            if (cnt[d] != 24) begin
                errors++;
                $display("FAIL onehot_count digit %0d: lit %0d cycles in 3 frames, want 24", d, cnt[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_display();
        test_mid_slot_load();
        test_back_to_back();
        test_bcd_wrap();
        test_reset_mid_show();
        test_random_onehot();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
